// File: rtl/dut_if_pkg.sv
// Shared types and constants for the dut write/read method interface.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dut_if_pkg;

   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DATA_W = 1;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   // Queued command as presented on the command port
   typedef struct packed {
      logic                  op;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } cmd_t;

   // Completed read as returned on the response port
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } rsp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and extra-MSB pointers.
// Latency: a push is visible at out_dat the cycle after it is accepted.
// Backpressure: in_rdy = not full; a push while full is refused even if a pop happens that cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic [WIDTH-1:0]         in_dat,
   input  logic                     out_rdy,
   output logic [WIDTH-1:0]         out_dat,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Full when the pointers alias to the same slot but differ in the wrap bit
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign push    = in_vld && !full;
   assign pop     = out_rdy && !empty;
   assign in_rdy  = !full;
   assign out_dat = mem[rd_ptr[AW-1:0]];
   assign count   = wr_ptr - rd_ptr;

   // Storage and pointers; storage is cleared so the head reads as zero out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_dat;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dut_initiator.sv
// In-order initiator for the dut write/read methods, with command and response queues.
// Latency: command accepted at edge N can raise its EN in the cycle after N; read data lands in the response queue at the EN edge.
// Backpressure: EN only with the matching RDY; reads also wait for response-queue space; cmd_ready drops when full or halted.
module dut_initiator
   import dut_if_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data,
   output logic              write_en,
   input  logic              write_rdy,
   output logic [ADDR_W-1:0] read_address,
   output logic              read_en,
   input  logic [DATA_W-1:0] read_data,
   input  logic              read_rdy,
   output logic              halted,
   output logic [15:0]       issued_cnt
);

   // Entry layouts follow the instance widths rather than the package defaults
   typedef struct packed {
      logic              op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_ent_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rsp_ent_t;

   localparam int CCW = $clog2(CMD_DEPTH) + 1;
   localparam int RCW = $clog2(RSP_DEPTH) + 1;
   localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   state_t           state;
   logic [WCW-1:0]   wait_cnt;

   cmd_ent_t         cmd_in;
   cmd_ent_t         cmd_head;
   logic             cmd_in_rdy;
   logic             cmd_push;
   logic             cmd_pop;
   logic [CCW-1:0]   cmd_count;

   rsp_ent_t         rsp_in;
   rsp_ent_t         rsp_head;
   logic             rsp_in_rdy;
   logic [RCW-1:0]   rsp_count;

   logic             active;
   logic             timeout_hit;

   assign cmd_in    = '{op: cmd_op, addr: cmd_addr, data: cmd_data};
   assign cmd_ready = cmd_in_rdy && (state != HALT);
   assign cmd_push  = cmd_valid && cmd_ready;

   // WAIT is held exactly while the command queue is non-empty, so it doubles as head-valid
   assign active   = (state == WAIT) && !halted;
   assign write_en = active && (cmd_head.op == OP_WRITE) && write_rdy;
   assign read_en  = active && (cmd_head.op == OP_READ) && read_rdy && rsp_in_rdy;
   assign cmd_pop  = write_en || read_en;

   assign write_address = cmd_head.addr;
   assign write_data    = cmd_head.data;
   assign read_address  = cmd_head.addr;

   assign rsp_in    = '{addr: cmd_head.addr, data: read_data};
   assign rsp_valid = (rsp_count != '0);
   assign rsp_addr  = rsp_head.addr;
   assign rsp_data  = rsp_head.data;

   // Fires on the stalled cycle that would bring the wait count up to TIMEOUT
   assign timeout_hit = (TIMEOUT != 0) && (32'(wait_cnt) == TIMEOUT - 1);

   sync_fifo #(
      .WIDTH ($bits(cmd_ent_t)),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk     (CLK),
      .rst     (RST),
      .in_vld  (cmd_push),
      .in_rdy  (cmd_in_rdy),
      .in_dat  (cmd_in),
      .out_rdy (cmd_pop),
      .out_dat (cmd_head),
      .count   (cmd_count)
   );

   sync_fifo #(
      .WIDTH ($bits(rsp_ent_t)),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (CLK),
      .rst     (RST),
      .in_vld  (read_en),
      .in_rdy  (rsp_in_rdy),
      .in_dat  (rsp_in),
      .out_rdy (rsp_ready),
      .out_dat (rsp_head),
      .count   (rsp_count)
   );

   // Issue FSM: tracks queue occupancy, counts stalls toward HALT and completed transactions
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         halted     <= 1'b0;
         issued_cnt <= '0;
      end else begin
         if (cmd_pop) begin
            issued_cnt <= issued_cnt + 16'd1;
         end
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (cmd_push) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cmd_pop) begin
                  wait_cnt <= '0;
                  if ((cmd_count == CCW'(1)) && !cmd_push) begin
                     state <= IDLE;
                  end
               end else if (timeout_hit) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            HALT: begin
               halted <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dut_initiator.sv
// Directed bench for dut_initiator acting as the dut slave, with an issue/response scoreboard.
// Latency: checks one-cycle command-to-EN and in-order response return.
// Backpressure: exercises RDY stalls, full response queue, timeout HALT and mid-stream reset.
module tb_dut_initiator;
   import dut_if_pkg::*;

   localparam int AW = DEF_ADDR_W;
   localparam int DW = DEF_DATA_W;

   logic          CLK = 1'b0;
   logic          RST;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [AW-1:0] rsp_addr;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;
   logic          write_en;
   logic          write_rdy;
   logic [AW-1:0] read_address;
   logic          read_en;
   logic [DW-1:0] read_data;
   logic          read_rdy;
   logic          halted;
   logic [15:0]   issued_cnt;

   always #5 CLK = ~CLK;

   dut_initiator #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .CMD_DEPTH (4),
      .RSP_DEPTH (4),
      .TIMEOUT   (16)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_addr      (cmd_addr),
      .cmd_data      (cmd_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_addr      (rsp_addr),
      .rsp_data      (rsp_data),
      .write_address (write_address),
      .write_data    (write_data),
      .write_en      (write_en),
      .write_rdy     (write_rdy),
      .read_address  (read_address),
      .read_en       (read_en),
      .read_data     (read_data),
      .read_rdy      (read_rdy),
      .halted        (halted),
      .issued_cnt    (issued_cnt)
   );

   // Slave storage seen by the initiator; shadow is the in-order reference model
   logic [DW-1:0] dut_mem [8] = '{default: '0};
   logic [DW-1:0] shadow  [8];
   assign read_data = dut_mem[read_address];

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   wr_pulses = 0;
   int   rd_pulses = 0;
   int   rsp_pops  = 0;
   int   wr_cyc = 0;
   int   rd_cyc = 0;
   int   push_cyc = 0;
   cmd_t exp_iss [$];
   rsp_t exp_rsp [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #2;
      end
   endtask

   task automatic reset_checks();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_write_en", 32'(write_en), 32'd0);
      check("rst_read_en", 32'(read_en), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_issued_cnt", 32'(issued_cnt), 32'd0);
      check("rst_write_address", 32'(write_address), 32'd0);
      check("rst_write_data", 32'(write_data), 32'd0);
      check("rst_read_address", 32'(read_address), 32'd0);
   endtask

   // Offers one command, waits a bounded time for acceptance, records expectations
   task automatic push_cmd(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit   ok;
      cmd_t c;
      rsp_t r;
      ok        = 1'b0;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge CLK);
         ok = (cmd_ready === 1'b1);
      end
      if (!ok) begin
         check("push_accept", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      push_cyc = cyc;
      c.op   = op;
      c.addr = a;
      c.data = d;
      exp_iss.push_back(c);
      if (op == OP_WRITE) begin
         shadow[a] = d;
      end else begin
         r.addr = a;
         r.data = shadow[a];
         exp_rsp.push_back(r);
      end
      @(posedge CLK);
      #2;
      cmd_valid = 1'b0;
   endtask

   // Dut-side monitor: scoreboard for every EN and every response handshake
   task automatic monitor();
      cmd_t e;
      rsp_t r;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            if (write_en || read_en) begin
               check("en_exclusive", 32'(write_en && read_en), 32'd0);
               if (write_en) begin
                  check("write_rdy_proto", 32'(write_rdy), 32'd1);
                  wr_pulses++;
                  wr_cyc = cyc;
               end
               if (read_en) begin
                  check("read_rdy_proto", 32'(read_rdy), 32'd1);
                  rd_pulses++;
                  rd_cyc = cyc;
               end
               if (exp_iss.size() == 0) begin
                  check("unexpected_en", 32'(write_en || read_en), 32'd0);
               end else begin
                  e = exp_iss.pop_front();
                  check("iss_op", 32'(read_en), 32'(e.op));
                  check("iss_addr", 32'(read_en ? read_address : write_address), 32'(e.addr));
                  if (write_en) begin
                     check("iss_wdata", 32'(write_data), 32'(e.data));
                     dut_mem[write_address] = write_data;
                  end
               end
            end
            if (rsp_valid && rsp_ready) begin
               rsp_pops++;
               if (exp_rsp.size() == 0) begin
                  check("unexpected_rsp", 32'(rsp_valid), 32'd0);
               end else begin
                  r = exp_rsp.pop_front();
                  check("rsp_addr", 32'(rsp_addr), 32'(r.addr));
                  check("rsp_data", 32'(rsp_data), 32'(r.data));
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, r0, p0, rc;
      RST       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      rsp_ready = 1'b1;
      write_rdy = 1'b1;
      read_rdy  = 1'b1;
      for (int i = 0; i < 8; i++) shadow[i] = '0;
      fork
         monitor();
      join_none

      // Reset state, with both RDYs high so EN gating is exercised
      step(3);
      @(negedge CLK);
      reset_checks();
      @(posedge CLK);
      #2;
      RST = 1'b0;

      // Single write: one EN pulse, one cycle after acceptance
      w0 = wr_pulses;
      push_cmd(OP_WRITE, 3'd5, 1'b1);
      step(3);
      check("t1_wr_pulses", 32'(wr_pulses - w0), 32'd1);
      check("t1_latency", 32'(wr_cyc - push_cyc), 32'd1);
      check("t1_issued", 32'(issued_cnt), 32'd1);

      // Write then read of the same address, back to back
      r0 = rd_pulses;
      p0 = rsp_pops;
      push_cmd(OP_WRITE, 3'd2, 1'b1);
      push_cmd(OP_READ, 3'd2, 1'b0);
      step(4);
      check("t2_rd_pulses", 32'(rd_pulses - r0), 32'd1);
      check("t2_rd_after_wr", 32'(rd_cyc - wr_cyc), 32'd1);
      check("t2_rsp_pops", 32'(rsp_pops - p0), 32'd1);
      check("t2_issued", 32'(issued_cnt), 32'd3);

      // Write held off by RDY for 10 cycles, no timeout
      write_rdy = 1'b0;
      w0 = wr_pulses;
      push_cmd(OP_WRITE, 3'd3, 1'b1);
      step(10);
      check("t3_no_wr_while_busy", 32'(wr_pulses - w0), 32'd0);
      write_rdy = 1'b1;
      rc = cyc;
      step(2);
      check("t3_wr_pulses", 32'(wr_pulses - w0), 32'd1);
      check("t3_first_rdy_cycle", 32'(wr_cyc), 32'(rc));
      check("t3_not_halted", 32'(halted), 32'd0);
      check("t3_issued", 32'(issued_cnt), 32'd4);

      // Six reads against a stalled response port: four fit, two wait
      rsp_ready = 1'b0;
      r0 = rd_pulses;
      p0 = rsp_pops;
      for (int i = 0; i < 6; i++) push_cmd(OP_READ, 3'(i), 1'b0);
      step(4);
      check("t4_rd_stall", 32'(rd_pulses - r0), 32'd4);
      check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      step(8);
      check("t4_rd_total", 32'(rd_pulses - r0), 32'd6);
      check("t4_rsp_total", 32'(rsp_pops - p0), 32'd6);
      check("t4_rsp_drained", 32'(rsp_valid), 32'd0);
      check("t4_issued", 32'(issued_cnt), 32'd10);
      check("t4_not_halted", 32'(halted), 32'd0);

      // Read never accepted: HALT exactly after 16 stalled cycles
      read_rdy = 1'b0;
      r0 = rd_pulses;
      push_cmd(OP_READ, 3'd7, 1'b0);
      step(15);
      @(negedge CLK);
      check("t5_halted_at_15", 32'(halted), 32'd0);
      @(posedge CLK);
      #2;
      check("t5_halted_at_16", 32'(halted), 32'd1);
      check("t5_cmd_ready", 32'(cmd_ready), 32'd0);
      read_rdy  = 1'b1;
      write_rdy = 1'b1;
      step(5);
      check("t5_no_en_halted", 32'(rd_pulses - r0), 32'd0);
      check("t5_read_en_low", 32'(read_en), 32'd0);
      check("t5_issued", 32'(issued_cnt), 32'd10);
      RST = 1'b1;
      exp_iss.delete();
      exp_rsp.delete();
      #1;
      check("t5_rst_clears_halted", 32'(halted), 32'd0);
      reset_checks();
      step(2);
      RST = 1'b0;

      // Full command queue: a pop in the same cycle does not open cmd_ready
      write_rdy = 1'b0;
      w0 = wr_pulses;
      push_cmd(OP_WRITE, 3'd1, 1'b1);
      push_cmd(OP_WRITE, 3'd4, 1'b0);
      push_cmd(OP_WRITE, 3'd6, 1'b1);
      push_cmd(OP_WRITE, 3'd0, 1'b1);
      @(negedge CLK);
      check("bf_full_ready", 32'(cmd_ready), 32'd0);
      @(posedge CLK);
      #2;
      write_rdy = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = OP_WRITE;
      cmd_addr  = 3'd3;
      cmd_data  = 1'b0;
      @(negedge CLK);
      check("bf_pop_cycle_ready", 32'(cmd_ready), 32'd0);
      check("bf_pop_cycle_en", 32'(write_en), 32'd1);
      push_cmd(OP_WRITE, 3'd3, 1'b0);
      step(8);
      check("bf_wr_pulses", 32'(wr_pulses - w0), 32'd5);
      check("bf_issued", 32'(issued_cnt), 32'd5);

      // Reset in the middle of a stalled, full queue
      write_rdy = 1'b0;
      read_rdy  = 1'b0;
      for (int i = 1; i <= 4; i++) push_cmd(OP_READ, 3'(i), 1'b0);
      @(negedge CLK);
      check("t6_full", 32'(cmd_ready), 32'd0);
      @(posedge CLK);
      #2;
      read_rdy = 1'b1;
      #1;
      check("t6_en_before_rst", 32'(read_en), 32'd1);
      RST = 1'b1;
      exp_iss.delete();
      exp_rsp.delete();
      #1;
      check("t6_en_drops_async", 32'(read_en), 32'd0);
      reset_checks();
      write_rdy = 1'b1;
      step(2);
      RST = 1'b0;
      w0 = wr_pulses;
      r0 = rd_pulses;
      step(5);
      check("t6_no_wr_after_rst", 32'(wr_pulses - w0), 32'd0);
      check("t6_no_rd_after_rst", 32'(rd_pulses - r0), 32'd0);
      push_cmd(OP_WRITE, 3'd6, 1'b1);
      step(3);
      check("t6_new_wr", 32'(wr_pulses - w0), 32'd1);
      check("t6_issued", 32'(issued_cnt), 32'd1);
      check("end_iss_queue", 32'(exp_iss.size()), 32'd0);
      check("end_rsp_queue", 32'(exp_rsp.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
